// File: rtl/udp_echo_engine.sv
// udp_echo_engine
//   Multi-channel UDP echo/transform stage placed between the RX UDP frame
//   output and the TX UDP frame input of a UDP stack. Frames addressed to
//   PORT_BASE .. PORT_BASE+NUM_PORTS-1 on an enabled channel are sent back to
//   their sender with a per-channel payload transform. All other frames are
//   consumed and counted as drops. The payload passes through an internal
//   circular FIFO so that the TX path is decoupled from RX.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_udp_hdr_*                RX header handshake and fields
//   s_udp_payload_axis_*       RX payload byte stream
//   m_udp_hdr_*, m_udp_ip_*    TX header handshake and fields
//   m_udp_payload_axis_*       TX payload byte stream
//   local_ip                   own IP, used as the TX source address
//   chan_enable, chan_mode     per-channel enable / transform mode,
//                              both sampled at header accept
//   stat_echo_frames           saturating count of echoed frames
//   stat_drop_frames           saturating count of dropped frames
//   busy                       FSM not idle or FIFO holding payload
//   dbg_state                  current FSM state (IDLE/HDR/FWD/DROP = 0..3)
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both high; a valid that is high stays
// high with its data stable until that transfer.
module udp_echo_engine #(
    parameter int          NUM_PORTS  = 4,
    parameter int          PORT_BASE  = 1234,
    parameter int          FIFO_DEPTH = 2048,
    parameter logic [7:0]  INC_VALUE  = 8'h01,
    parameter logic [7:0]  TX_TTL     = 8'd64
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   s_udp_hdr_valid,
    output logic                   s_udp_hdr_ready,
    input  logic [31:0]            s_udp_ip_source_ip,
    input  logic [15:0]            s_udp_source_port,
    input  logic [15:0]            s_udp_dest_port,
    input  logic [15:0]            s_udp_length,
    input  logic [7:0]             s_udp_payload_axis_tdata,
    input  logic                   s_udp_payload_axis_tvalid,
    output logic                   s_udp_payload_axis_tready,
    input  logic                   s_udp_payload_axis_tlast,
    input  logic                   s_udp_payload_axis_tuser,

    output logic                   m_udp_hdr_valid,
    input  logic                   m_udp_hdr_ready,
    output logic [5:0]             m_udp_ip_dscp,
    output logic [1:0]             m_udp_ip_ecn,
    output logic [7:0]             m_udp_ip_ttl,
    output logic [31:0]            m_udp_ip_source_ip,
    output logic [31:0]            m_udp_ip_dest_ip,
    output logic [15:0]            m_udp_source_port,
    output logic [15:0]            m_udp_dest_port,
    output logic [15:0]            m_udp_length,
    output logic [15:0]            m_udp_checksum,
    output logic [7:0]             m_udp_payload_axis_tdata,
    output logic                   m_udp_payload_axis_tvalid,
    input  logic                   m_udp_payload_axis_tready,
    output logic                   m_udp_payload_axis_tlast,
    output logic                   m_udp_payload_axis_tuser,

    input  logic [31:0]            local_ip,
    input  logic [NUM_PORTS-1:0]   chan_enable,
    input  logic [2*NUM_PORTS-1:0] chan_mode,
    output logic [31:0]            stat_echo_frames,
    output logic [31:0]            stat_drop_frames,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_FWD  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Goes high one cycle after reset release; keeps the header ready low
    // while reset is asserted even though the FSM already sits in IDLE.
    logic active;

    logic        hdr_accept;
    logic        beat_accept;
    logic        fifo_full;
    logic        fifo_empty;

    // ------------------------------------------------------------------
    // Channel lookup. The offset is computed in 17 bits so ports below
    // PORT_BASE wrap to large values and never match a channel index.
    // ------------------------------------------------------------------
    logic [16:0] port_off;
    logic        hit;
    logic [1:0]  hit_mode;

    assign port_off = {1'b0, s_udp_dest_port} - 17'(PORT_BASE);

    always_comb begin
        hit      = 1'b0;
        hit_mode = 2'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_off == 17'(i)) begin
                hit      = chan_enable[i];
                hit_mode = chan_mode[2*i +: 2];
            end
        end
    end

    function automatic logic [7:0] xform(input logic [1:0] mode, input logic [7:0] d);
        case (mode)
            2'd1:    xform = d + INC_VALUE;
            2'd2:    xform = ~d;
            default: xform = d;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hdr_accept) state_nxt = hit ? ST_HDR : ST_DROP;
            ST_HDR:  if (m_udp_hdr_ready) state_nxt = ST_FWD;
            ST_FWD:  if (beat_accept && s_udp_payload_axis_tlast) state_nxt = ST_IDLE;
            ST_DROP: if (beat_accept && s_udp_payload_axis_tlast) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_udp_hdr_ready           = 1'b0;
        m_udp_hdr_valid           = 1'b0;
        s_udp_payload_axis_tready = 1'b0;
        case (state)
            ST_IDLE: s_udp_hdr_ready           = active;
            ST_HDR:  m_udp_hdr_valid           = 1'b1;
            ST_FWD:  s_udp_payload_axis_tready = !fifo_full;
            ST_DROP: s_udp_payload_axis_tready = 1'b1;
            default: ;
        endcase
    end

    assign hdr_accept  = s_udp_hdr_valid && s_udp_hdr_ready;
    assign beat_accept = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
    assign dbg_state   = state;

    // ------------------------------------------------------------------
    // Header latch (source/destination swapped for the reply)
    // ------------------------------------------------------------------
    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_udp_ip_dest_ip  <= '0;
            m_udp_source_port <= '0;
            m_udp_dest_port   <= '0;
            m_udp_length      <= '0;
            mode_q            <= '0;
        end else if (hdr_accept) begin
            m_udp_ip_dest_ip  <= s_udp_ip_source_ip;
            m_udp_source_port <= s_udp_dest_port;
            m_udp_dest_port   <= s_udp_source_port;
            m_udp_length      <= s_udp_length;
            mode_q            <= hit_mode;
        end
    end

    assign m_udp_ip_dscp      = 6'd0;
    assign m_udp_ip_ecn       = 2'd0;
    assign m_udp_ip_ttl       = TX_TTL;
    assign m_udp_ip_source_ip = local_ip;
    assign m_udp_checksum     = 16'd0;

    // ------------------------------------------------------------------
    // Frame counters, saturating
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_echo_frames <= '0;
            stat_drop_frames <= '0;
        end else if (beat_accept && s_udp_payload_axis_tlast) begin
            if (state == ST_FWD && stat_echo_frames != 32'hFFFF_FFFF)
                stat_echo_frames <= stat_echo_frames + 32'd1;
            if (state == ST_DROP && stat_drop_frames != 32'hFFFF_FFFF)
                stat_drop_frames <= stat_drop_frames + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Payload FIFO. Entries are {tuser, tlast, data}. The read pointer
    // only advances when the TX side takes a beat, so the output register
    // always mirrors the entry at rd_ptr and the full flag covers every
    // byte held by the block, including the one being presented.
    // ------------------------------------------------------------------
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_nxt;
    logic        wr_en;
    logic        rd_pop;
    logic [9:0]  out_word;

    assign wr_en      = (state == ST_FWD) && beat_accept;
    assign rd_pop     = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready;
    assign rd_nxt     = rd_ptr + (AW+1)'(rd_pop);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {s_udp_payload_axis_tuser, s_udp_payload_axis_tlast,
                                    xform(mode_q, s_udp_payload_axis_tdata)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr                    <= '0;
            rd_ptr                    <= '0;
            out_word                  <= '0;
            m_udp_payload_axis_tvalid <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_nxt;
            // A byte written on this edge is excluded here, which gives
            // the one-cycle write-to-output latency of a registered read.
            m_udp_payload_axis_tvalid <= (wr_ptr != rd_nxt);
            if (wr_ptr != rd_nxt)
                out_word <= mem[rd_nxt[AW-1:0]];
        end
    end

    assign m_udp_payload_axis_tdata = out_word[7:0];
    assign m_udp_payload_axis_tlast = out_word[8];
    assign m_udp_payload_axis_tuser = out_word[9];

    assign busy = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_udp_echo_engine.sv
// Directed testbench for udp_echo_engine (NUM_PORTS=4, PORT_BASE=1234,
// FIFO_DEPTH=16). Inputs change 1 time unit after the rising edge; the TX
// side is observed on the falling edge, where a high valid/ready pair means
// a transfer on the following rising edge.
module tb_udp_echo_engine;

    localparam int LIMIT = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        s_hdr_valid = 1'b0;
    logic        s_hdr_ready;
    logic [31:0] s_src_ip = '0;
    logic [15:0] s_src_port = '0;
    logic [15:0] s_dst_port = '0;
    logic [15:0] s_len = '0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;

    logic        m_hdr_valid;
    logic        m_hdr_ready = 1'b1;
    logic [5:0]  m_dscp;
    logic [1:0]  m_ecn;
    logic [7:0]  m_ttl;
    logic [31:0] m_src_ip;
    logic [31:0] m_dst_ip;
    logic [15:0] m_src_port;
    logic [15:0] m_dst_port;
    logic [15:0] m_len;
    logic [15:0] m_csum;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;

    logic [31:0] local_ip = 32'hC0A8_0101;
    logic [3:0]  chan_enable = 4'b0111;
    logic [7:0]  chan_mode = 8'b11_10_01_00;
    logic [31:0] stat_echo;
    logic [31:0] stat_drop;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    int          hdr_cnt = 0;
    logic [31:0] cap_dst_ip;
    logic [31:0] cap_src_ip;
    logic [15:0] cap_src_port;
    logic [15:0] cap_dst_port;
    logic [15:0] cap_len;
    logic [7:0]  cap_ttl;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    udp_echo_engine #(
        .NUM_PORTS (4),
        .PORT_BASE (1234),
        .FIFO_DEPTH(16),
        .INC_VALUE (8'h01),
        .TX_TTL    (8'd64)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_udp_hdr_valid           (s_hdr_valid),
        .s_udp_hdr_ready           (s_hdr_ready),
        .s_udp_ip_source_ip        (s_src_ip),
        .s_udp_source_port         (s_src_port),
        .s_udp_dest_port           (s_dst_port),
        .s_udp_length              (s_len),
        .s_udp_payload_axis_tdata  (s_tdata),
        .s_udp_payload_axis_tvalid (s_tvalid),
        .s_udp_payload_axis_tready (s_tready),
        .s_udp_payload_axis_tlast  (s_tlast),
        .s_udp_payload_axis_tuser  (s_tuser),
        .m_udp_hdr_valid           (m_hdr_valid),
        .m_udp_hdr_ready           (m_hdr_ready),
        .m_udp_ip_dscp             (m_dscp),
        .m_udp_ip_ecn              (m_ecn),
        .m_udp_ip_ttl              (m_ttl),
        .m_udp_ip_source_ip        (m_src_ip),
        .m_udp_ip_dest_ip          (m_dst_ip),
        .m_udp_source_port         (m_src_port),
        .m_udp_dest_port           (m_dst_port),
        .m_udp_length              (m_len),
        .m_udp_checksum            (m_csum),
        .m_udp_payload_axis_tdata  (m_tdata),
        .m_udp_payload_axis_tvalid (m_tvalid),
        .m_udp_payload_axis_tready (m_tready),
        .m_udp_payload_axis_tlast  (m_tlast),
        .m_udp_payload_axis_tuser  (m_tuser),
        .local_ip                  (local_ip),
        .chan_enable               (chan_enable),
        .chan_mode                 (chan_mode),
        .stat_echo_frames          (stat_echo),
        .stat_drop_frames          (stat_drop),
        .busy                      (busy),
        .dbg_state                 (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every TX beat is compared with the head of exp_q; a beat
    // arriving with nothing expected is compared against an impossible word.
    always @(negedge clk) begin
        if (m_hdr_valid && m_hdr_ready) begin
            cap_dst_ip   = m_dst_ip;
            cap_src_ip   = m_src_ip;
            cap_src_port = m_src_port;
            cap_dst_port = m_dst_port;
            cap_len      = m_len;
            cap_ttl      = m_ttl;
            hdr_cnt++;
        end
        if (m_tvalid && m_tready) begin
            logic [31:0] want;
            want = (exp_q.size() > 0) ? {22'd0, exp_q.pop_front()} : 32'hDEAD_0400;
            check("tx_beat", {22'd0, m_tuser, m_tlast, m_tdata}, want);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [15:0] dport, input logic [15:0] sport,
                            input logic [15:0] len, input logic [31:0] ip);
        int n;
        s_hdr_valid = 1'b1;
        s_dst_port  = dport;
        s_src_port  = sport;
        s_len       = len;
        s_src_ip    = ip;
        n = 0;
        while (!s_hdr_ready && n < LIMIT) begin
            tick();
            n++;
        end
        check("hdr_accept_in_time", 32'(n < LIMIT), 32'd1);
        tick();
        s_hdr_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        n = 0;
        while (!s_tready && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT)
            check("beat_accept_in_time", 32'(n), 32'(LIMIT - 1));
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < LIMIT) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int h0;

        // Reset state
        #2;
        check("rst_hdr_ready", 32'(s_hdr_ready), 32'd0);
        check("rst_m_hdr_valid", 32'(m_hdr_valid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_echo", stat_echo, 32'd0);
        check("rst_drop", stat_drop, 32'd0);
        check("rst_len", 32'(m_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Channel 0, mode 0: plain echo with swapped ports
        exp_q.push_back(10'h000);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h002);
        exp_q.push_back(10'h103);
        send_hdr(16'd1234, 16'd5000, 16'd12, 32'hC0A8_0164);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b1, 1'b0);
        wait_drain("drain_t1");
        check("t1_hdr_cnt", 32'(hdr_cnt), 32'd1);
        check("t1_dst_port", 32'(cap_dst_port), 32'd5000);
        check("t1_src_port", 32'(cap_src_port), 32'd1234);
        check("t1_len", 32'(cap_len), 32'd12);
        check("t1_dst_ip", cap_dst_ip, 32'hC0A8_0164);
        check("t1_src_ip", cap_src_ip, 32'hC0A8_0101);
        check("t1_ttl", 32'(cap_ttl), 32'd64);
        check("t1_csum", 32'(m_csum), 32'd0);
        check("t1_echo", stat_echo, 32'd1);

        // Channel 1 mode 1 (increment with wrap), channel 2 mode 2 (invert)
        exp_q.push_back(10'h0FF);
        exp_q.push_back(10'h100);
        send_hdr(16'd1235, 16'd6000, 16'd10, 32'h0A00_0002);
        send_byte(8'hFE, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        exp_q.push_back(10'h1F0);
        send_hdr(16'd1236, 16'd6001, 16'd9, 32'h0A00_0003);
        send_byte(8'h0F, 1'b1, 1'b0);
        wait_drain("drain_t2");
        check("t2_src_port", 32'(cap_src_port), 32'd1236);
        check("t2_echo", stat_echo, 32'd3);

        // Drops: port outside the range, then a disabled channel
        h0 = hdr_cnt;
        send_hdr(16'd80, 16'd7000, 16'd10, 32'h0A00_0004);
        check("t3_drop_tready", 32'(s_tready), 32'd1);
        check("t3_no_hdr_valid", 32'(m_hdr_valid), 32'd0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_hdr(16'd1237, 16'd7001, 16'd9, 32'h0A00_0005);
        send_byte(8'h33, 1'b1, 1'b0);
        wait_drain("drain_t3");
        check("t3_hdr_cnt", 32'(hdr_cnt - h0), 32'd0);
        check("t3_drop", stat_drop, 32'd2);
        check("t3_echo", stat_echo, 32'd3);

        // FIFO fill: TX stalled, 20-byte frame into a 16-byte FIFO
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++)
            exp_q.push_back({1'b0, (i == 19), 8'(i)});
        send_hdr(16'd1234, 16'd5001, 16'd28, 32'h0A00_0006);
        for (int i = 0; i < 16; i++)
            send_byte(8'(i), 1'b0, 1'b0);
        tick();
        tick();
        check("t4_full_tready", 32'(s_tready), 32'd0);
        check("t4_hold_tvalid", 32'(m_tvalid), 32'd1);
        check("t4_hold_tdata", 32'(m_tdata), 32'd0);
        m_tready = 1'b1;
        for (int i = 16; i < 20; i++)
            send_byte(8'(i), (i == 19), 1'b0);
        wait_drain("drain_t4");
        check("t4_echo", stat_echo, 32'd4);

        // Reset in the middle of a payload
        m_tready = 1'b0;
        send_hdr(16'd1234, 16'd5002, 16'd12, 32'h0A00_0007);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_m_tvalid", 32'(m_tvalid), 32'd0);
        check("t5_hdr_ready", 32'(s_hdr_ready), 32'd0);
        check("t5_echo", stat_echo, 32'd0);
        check("t5_drop", stat_drop, 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        m_tready = 1'b1;
        tick();
        exp_q.push_back(10'h05A);
        exp_q.push_back(10'h1A5);
        send_hdr(16'd1234, 16'd5003, 16'd10, 32'h0A00_0008);
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_drain("drain_t5");
        check("t5_echo_after", stat_echo, 32'd1);
        check("t5_dst_port", 32'(cap_dst_port), 32'd5003);

        // Back-to-back frames, tuser on the first frame's last beat only
        h0 = hdr_cnt;
        exp_q.push_back(10'h011);
        exp_q.push_back(10'h322);
        exp_q.push_back(10'h034);
        exp_q.push_back(10'h145);
        send_hdr(16'd1234, 16'd5004, 16'd10, 32'h0A00_0009);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b1);
        send_hdr(16'd1235, 16'd5005, 16'd10, 32'h0A00_000A);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        wait_drain("drain_t6");
        check("t6_hdr_cnt", 32'(hdr_cnt - h0), 32'd2);
        check("t6_echo", stat_echo, 32'd3);
        check("t6_state_idle", 32'(dbg_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
